// File: rtl/load_store_unit.sv
// Memory-access stage in front of a single-port data memory: word/byte loads and stores,
// byte stores via read-modify-write, misaligned word accesses answered with an error pulse.
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_write_in,
    input  logic              req_byte_in,
    input  logic [ADDR_W+1:0] req_addr_in,
    input  logic [DATA_W-1:0] req_wdata_in,
    output logic              resp_valid_out,
    output logic [DATA_W-1:0] resp_rdata_out,
    output logic              align_err_out,
    output logic              mem_write_en_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              accept_s;
    logic              req_write_r, req_byte_r;
    logic [1:0]        lane_r;
    logic [7:0]        wbyte_r;
    logic              ready_r, resp_valid_r, align_err_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_data_r, resp_rdata_r;

    // Replace one byte lane of a word; lane 0 is bits [7:0].
    function automatic logic [DATA_W-1:0] merge_byte(input logic [DATA_W-1:0] word,
                                                     input logic [1:0] lane,
                                                     input logic [7:0] b);
        logic [DATA_W-1:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = b;
            2'd1:    res[15:8]  = b;
            2'd2:    res[23:16] = b;
            2'd3:    res[31:24] = b;
            default: res        = word;
        endcase
        return res;
    endfunction

    // Pick one byte lane and zero-extend it to a full word.
    function automatic logic [DATA_W-1:0] extract_byte(input logic [DATA_W-1:0] word,
                                                       input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return {{(DATA_W-8){1'b0}}, b};
    endfunction

    assign accept_s = req_valid_in & ready_r;

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (!req_byte_in && (req_addr_in[1:0] != 2'b00)) begin
                    state_nxt_s = ST_ERR;
                end else if (req_write_in && !req_byte_in) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_READ: begin
                if (req_write_r) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_WRITE: state_nxt_s = ST_RESP;
            ST_RESP:  state_nxt_s = ST_IDLE;
            ST_ERR:   state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Control outputs registered from the upcoming state so they align with it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            align_err_r  <= 1'b0;
            mem_we_r     <= 1'b0;
        end else begin
            ready_r      <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_RESP) || (state_nxt_s == ST_ERR);
            align_err_r  <= (state_nxt_s == ST_ERR);
            mem_we_r     <= (state_nxt_s == ST_WRITE);
        end
    end

    // Request capture, memory address/data and response data.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            req_write_r  <= 1'b0;
            req_byte_r   <= 1'b0;
            lane_r       <= 2'b00;
            wbyte_r      <= 8'h00;
            mem_addr_r   <= '0;
            mem_data_r   <= '0;
            resp_rdata_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        req_write_r <= req_write_in;
                        req_byte_r  <= req_byte_in;
                        lane_r      <= req_addr_in[1:0];
                        wbyte_r     <= req_wdata_in[7:0];
                        mem_addr_r  <= req_addr_in[ADDR_W+1:2];
                        if (state_nxt_s == ST_WRITE) begin
                            mem_data_r <= req_wdata_in;
                        end
                        if (state_nxt_s == ST_ERR) begin
                            resp_rdata_r <= '0;
                        end
                    end
                end
                ST_READ: begin
                    if (req_write_r) begin
                        mem_data_r <= merge_byte(mem_data_in, lane_r, wbyte_r);
                    end else if (req_byte_r) begin
                        resp_rdata_r <= extract_byte(mem_data_in, lane_r);
                    end else begin
                        resp_rdata_r <= mem_data_in;
                    end
                end
                ST_WRITE: resp_rdata_r <= '0;
                default: ;
            endcase
        end
    end

    assign req_ready_out    = ready_r;
    assign resp_valid_out   = resp_valid_r;
    assign align_err_out    = align_err_r;
    assign resp_rdata_out   = resp_rdata_r;
    assign mem_write_en_out = mem_we_r;
    assign mem_addr_out     = mem_addr_r;
    assign mem_data_out     = mem_data_r;

endmodule
